// File: rtl/sobel_window.sv
// sobel_window: shifts one 3-pixel column per handshake into a 3x3 window and
// emits |Gx|+|Gy| with an edge flag through a 2-stage stallable pipeline.
module sobel_window #(
  parameter int length      = 640,
  parameter int pixel_width = 8,
  parameter int threshold   = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din_a,
  input  logic [31:0] din_b,
  input  logic [31:0] din_c,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        din_last,
  output logic [31:0] dout,
  output logic        dout_edge,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_last
);

  localparam int GW = pixel_width + 4;
  localparam int MW = pixel_width + 3;

  // element [2] is the newest (right) column, [0] the oldest (left)
  logic [2:0][pixel_width-1:0] win_a_r, win_b_r, win_c_r;
  logic [9:0]                  col_cnt_r;
  logic                        s0_valid_r, s0_last_r, s1_valid_r, s1_last_r;
  logic signed [GW-1:0]        gx_r, gy_r;

  logic                 stall_s, acc_s, row_end_s, win_full_s;
  logic signed [GW-1:0] gx_s, gy_s;
  logic [MW-1:0]        mag_s;
  logic                 unused_din_s;

  function automatic logic signed [GW-1:0] tap_sum(input logic [pixel_width-1:0] p,
                                                   input logic [pixel_width-1:0] q,
                                                   input logic [pixel_width-1:0] r);
    return GW'(p) + (GW'(q) << 1) + GW'(r);
  endfunction

  function automatic logic [MW-1:0] abs_mag(input logic signed [GW-1:0] g);
    return MW'(g[GW-1] ? -g : g);
  endfunction

  // handshake, row-end detection and the combinational Sobel arithmetic
  always_comb begin
    stall_s    = dout_valid & ~dout_ready;
    acc_s      = din_valid & ~stall_s;
    row_end_s  = din_last | (col_cnt_r == 10'(length - 1));
    win_full_s = (col_cnt_r >= 10'd2);
    gx_s       = tap_sum(win_a_r[2], win_b_r[2], win_c_r[2])
               - tap_sum(win_a_r[0], win_b_r[0], win_c_r[0]);
    gy_s       = tap_sum(win_c_r[0], win_c_r[1], win_c_r[2])
               - tap_sum(win_a_r[0], win_a_r[1], win_a_r[2]);
    mag_s      = abs_mag(gx_r) + abs_mag(gy_r);
  end

  assign din_ready    = ~stall_s;
  assign unused_din_s = ^{din_a[31:pixel_width], din_b[31:pixel_width], din_c[31:pixel_width]};

  // window, column counter and both pipeline stages; everything holds while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_a_r    <= '0;
      win_b_r    <= '0;
      win_c_r    <= '0;
      col_cnt_r  <= 10'd0;
      s0_valid_r <= 1'b0;
      s0_last_r  <= 1'b0;
      gx_r       <= '0;
      gy_r       <= '0;
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      dout       <= 32'd0;
      dout_edge  <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else if (!stall_s) begin
      if (acc_s) begin
        win_a_r   <= {din_a[pixel_width-1:0], win_a_r[2:1]};
        win_b_r   <= {din_b[pixel_width-1:0], win_b_r[2:1]};
        win_c_r   <= {din_c[pixel_width-1:0], win_c_r[2:1]};
        col_cnt_r <= row_end_s ? 10'd0 : col_cnt_r + 10'd1;
      end
      // counter gating alone keeps windows from spanning a row boundary
      s0_valid_r <= acc_s & win_full_s;
      s0_last_r  <= acc_s & win_full_s & row_end_s;
      gx_r       <= gx_s;
      gy_r       <= gy_s;
      s1_valid_r <= s0_valid_r;
      s1_last_r  <= s0_last_r;
      dout       <= 32'(mag_s);
      dout_edge  <= (mag_s >= MW'(threshold));
      dout_valid <= s1_valid_r;
      dout_last  <= s1_last_r;
    end
  end

endmodule

// File: tb/tb_sobel_window.sv
// Self-checking bench for sobel_window: table-driven columns feed a scoreboard
// queue; a negedge monitor checks results, ready and stall stability.
module tb_sobel_window;

  localparam int LEN = 8;

  typedef struct {
    logic [7:0]  a, b, c;
    logic        last;
    logic        has_out;
    logic [10:0] mag;
    logic        edge_f;
    logic        out_last;
  } vec_t;

  typedef struct {
    logic [10:0] mag;
    logic        edge_f;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] din_a = 32'd0, din_b = 32'd0, din_c = 32'd0;
  logic        din_valid = 1'b0, din_last = 1'b0, dout_ready = 1'b1;
  logic        din_ready, dout_edge, dout_valid, dout_last;
  logic [31:0] dout;

  vec_t tbl[$];
  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_fail = 0;
  int   rdy_mode = 0;
  logic prev_stall = 1'b0;
  logic [33:0] prev_vals = 34'd0;
  int   vs_lo, vs_hi, fr_lo, fr_hi;

  sobel_window #(.length(LEN), .pixel_width(8), .threshold(128)) dut (
    .clk(clk), .rst(rst),
    .din_a(din_a), .din_b(din_b), .din_c(din_c),
    .din_valid(din_valid), .din_ready(din_ready), .din_last(din_last),
    .dout(dout), .dout_edge(dout_edge), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last)
  );

  always #5 clk = ~clk;

  // downstream ready: 0 = always ready, 1 = random, 2 = blocked
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       dout_ready = 1'($urandom_range(0, 1));
        2:       dout_ready = 1'b0;
        default: dout_ready = 1'b1;
      endcase
    end
  end

  // monitor: ready rule, stall stability and scoreboard compare
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        n_vec++;
        if (din_ready !== ~(dout_valid & ~dout_ready)) begin
          n_fail++;
          $display("FAIL din_ready_rule: got %0b, required %0b", din_ready, ~(dout_valid & ~dout_ready));
        end
        if (prev_stall) begin
          n_vec++;
          if ({dout, dout_edge, dout_last} !== prev_vals) begin
            n_fail++;
            $display("FAIL stall_hold: got %h, required %h", {dout, dout_edge, dout_last}, prev_vals);
          end
        end
        if (dout_valid && dout_ready) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_result: got dout=%0d edge=%0b last=%0b, required no result",
                     dout, dout_edge, dout_last);
          end else begin
            mon_e = exp_q.pop_front();
            if (dout !== {21'd0, mon_e.mag} || dout_edge !== mon_e.edge_f || dout_last !== mon_e.last) begin
              n_fail++;
              $display("FAIL result: got dout=%0d edge=%0b last=%0b, required dout=%0d edge=%0b last=%0b",
                       dout, dout_edge, dout_last, mon_e.mag, mon_e.edge_f, mon_e.last);
            end
          end
        end
        prev_stall = dout_valid & ~dout_ready;
        prev_vals  = {dout, dout_edge, dout_last};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  function automatic void add(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic last, input logic has_out, input logic [10:0] mag,
                              input logic edge_f, input logic out_last);
    vec_t v;
    v.a = a; v.b = b; v.c = c; v.last = last; v.has_out = has_out;
    v.mag = mag; v.edge_f = edge_f; v.out_last = out_last;
    tbl.push_back(v);
  endfunction

  // a=b=c column helper
  function automatic void addv(input logic [7:0] v, input logic last, input logic has_out,
                               input logic [10:0] mag, input logic edge_f, input logic out_last);
    add(v, v, v, last, has_out, mag, edge_f, out_last);
  endfunction

  // call aligned at posedge+1; returns aligned at posedge+1 after the accept edge
  task automatic send_col(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic last, output bit ok);
    int tries;
    din_a = {24'($urandom), a};
    din_b = {24'($urandom), b};
    din_c = {24'($urandom), c};
    din_last  = last;
    din_valid = 1'b1;
    ok = 1'b0;
    tries = 0;
    while (!ok && tries < 200) begin
      @(negedge clk);
      if (din_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      tries++;
    end
    din_valid = 1'b0;
    din_last  = 1'b0;
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: got din_ready=0 for %0d cycles, required acceptance", tries);
    end
  endtask

  task automatic run_range(input int lo, input int hi);
    bit ok;
    exp_t e;
    for (int i = lo; i < hi; i++) begin
      if (rdy_mode == 1 && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_col(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].last, ok);
      if (ok && tbl[i].has_out) begin
        e.mag = tbl[i].mag; e.edge_f = tbl[i].edge_f; e.last = tbl[i].out_last;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || dout_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit   ok;
    exp_t e;

    // flat image, one full row of LEN columns
    for (int j = 0; j < 8; j++) addv(8'd100, j == 7, j >= 2, 11'd0, 1'b0, j == 7);
    // vertical step
    vs_lo = tbl.size();
    addv(8'd0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0);
    addv(8'd0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0);
    addv(8'd0, 1'b0, 1'b1, 11'd0, 1'b0, 1'b0);
    addv(8'd255, 1'b0, 1'b1, 11'd1020, 1'b1, 1'b0);
    addv(8'd255, 1'b0, 1'b1, 11'd1020, 1'b1, 1'b0);
    addv(8'd255, 1'b1, 1'b1, 11'd0, 1'b0, 1'b1);
    vs_hi = tbl.size();
    // horizontal step
    for (int j = 0; j < 5; j++) add(8'd0, 8'd128, 8'd255, j == 4, j >= 2, 11'd1020, 1'b1, j == 4);
    // falling steps exercise negative gradients
    addv(8'd255, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0);
    addv(8'd255, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0);
    addv(8'd0, 1'b0, 1'b1, 11'd1020, 1'b1, 1'b0);
    addv(8'd0, 1'b1, 1'b1, 11'd1020, 1'b1, 1'b1);
    for (int j = 0; j < 3; j++) add(8'd255, 8'd128, 8'd0, j == 2, j >= 2, 11'd1020, 1'b1, j == 2);
    // mixed gradient: Gx=400, Gy=-200
    addv(8'd0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0);
    addv(8'd0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0);
    add(8'd200, 8'd100, 8'd0, 1'b1, 1'b1, 11'd600, 1'b1, 1'b1);
    // short row, then threshold just below and exactly at 128
    add(8'd50, 8'd60, 8'd70, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0);
    add(8'd90, 8'd80, 8'd70, 1'b1, 1'b0, 11'd0, 1'b0, 1'b0);
    addv(8'd10, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0);
    addv(8'd20, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0);
    addv(8'd40, 1'b1, 1'b1, 11'd120, 1'b0, 1'b1);
    addv(8'd10, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0);
    addv(8'd20, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0);
    addv(8'd42, 1'b1, 1'b1, 11'd128, 1'b1, 1'b1);
    // forced row ends without din_last, then din_last coincident with the bound
    fr_lo = tbl.size();
    for (int j = 0; j < 8; j++) addv(8'(j * 16), 1'b0, j >= 2, 11'd128, 1'b1, j == 7);
    for (int j = 0; j < 8; j++) addv(8'(j * 8), 1'b0, j >= 2, 11'd64, 1'b0, j == 7);
    for (int j = 0; j < 8; j++) addv(8'(j * 16), j == 7, j >= 2, 11'd128, 1'b1, j == 7);
    addv(8'd10, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0);
    addv(8'd20, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0);
    addv(8'd42, 1'b1, 1'b1, 11'd128, 1'b1, 1'b1);
    fr_hi = tbl.size();

    // reset held with valid high: outputs zero, nothing accepted
    din_valid = 1'b1;
    din_a = 32'd77; din_b = 32'd88; din_c = 32'd99;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout_edge", 32'(dout_edge), 32'd0);
    check("rst_dout_last", 32'(dout_last), 32'd0);
    check("rst_din_ready", 32'(din_ready), 32'd1);
    din_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(din_ready), 32'd1);
    check("post_rst_valid", 32'(dout_valid), 32'd0);
    @(posedge clk);
    #1;

    // latency: result valid two edges after the third accepted column
    send_col(8'd100, 8'd100, 8'd100, 1'b0, ok);
    send_col(8'd100, 8'd100, 8'd100, 1'b0, ok);
    send_col(8'd100, 8'd100, 8'd100, 1'b1, ok);
    e.mag = 11'd0; e.edge_f = 1'b0; e.last = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    check("lat_edge_k0", 32'(dout_valid), 32'd0);
    @(negedge clk);
    check("lat_edge_k1", 32'(dout_valid), 32'd0);
    @(negedge clk);
    check("lat_edge_k2", 32'(dout_valid), 32'd1);
    @(posedge clk);
    #1;

    // full-rate table run
    run_range(0, tbl.size());
    drain();

    // random backpressure and bubbles over the same streams
    rdy_mode = 1;
    repeat (3) run_range(vs_lo, vs_hi);
    run_range(fr_lo, fr_hi);
    drain();
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // reset pulse mid-row while a result is stalled at the output
    send_col(8'd0, 8'd0, 8'd0, 1'b0, ok);
    send_col(8'd0, 8'd0, 8'd0, 1'b0, ok);
    send_col(8'd255, 8'd255, 8'd255, 1'b0, ok);
    rdy_mode = 2;
    send_col(8'd255, 8'd255, 8'd255, 1'b0, ok);
    @(negedge clk);
    @(negedge clk);
    check("mr_stalled_valid", 32'(dout_valid), 32'd1);
    check("mr_stalled_ready", 32'(din_ready), 32'd0);
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("mr_rst_dout", dout, 32'd0);
    check("mr_rst_valid", 32'(dout_valid), 32'd0);
    check("mr_rst_edge", 32'(dout_edge), 32'd0);
    check("mr_rst_last", 32'(dout_last), 32'd0);
    check("mr_rst_ready", 32'(din_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    send_col(8'd10, 8'd10, 8'd10, 1'b0, ok);
    send_col(8'd20, 8'd20, 8'd20, 1'b0, ok);
    send_col(8'd42, 8'd42, 8'd42, 1'b1, ok);
    e.mag = 11'd128; e.edge_f = 1'b1; e.last = 1'b1;
    exp_q.push_back(e);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
